// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM state encoding and a small op-class helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_absval.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and for result sign fix-up.
module muldiv_absval #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] val,
    output logic [N-1:0] res
);

    assign res = neg ? (~val + N'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with Hi/Lo registers.
// Define MULDIV_UNSIGNED_EN to compile in MULTU/DIVU; otherwise all ops are signed.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t state;
    state_t stateNext;

    logic [CW-1:0]    cnt;
    logic             opDiv;
    logic             qNeg;
    logic             rNeg;
    logic [WIDTH:0]   opnd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;

    logic             signedOp;
    logic             isDiv;
    logic             negA;
    logic             negB;
    logic             divByZero;
    logic             lastIter;
    logic [WIDTH:0]   magA;
    logic [WIDTH:0]   magB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH+1:0] divDiff;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;

`ifdef MULDIV_UNSIGNED_EN
    assign signedOp = ~op[0];
`else
    assign signedOp = 1'b1;
`endif

    assign isDiv     = isDivOp(op);
    assign negA      = signedOp & a[WIDTH-1];
    assign negB      = signedOp & b[WIDTH-1];
    assign divByZero = isDiv && (b == '0);
    assign lastIter  = (cnt == CW'(WIDTH));

    // Sign-extend into WIDTH+1 bits so the most-negative value negates cleanly
    muldiv_absval #(.N(WIDTH + 1)) uAbsA (
        .neg (negA),
        .val ({negA, a}),
        .res (magA)
    );

    muldiv_absval #(.N(WIDTH + 1)) uAbsB (
        .neg (negB),
        .val ({negB, b}),
        .res (magB)
    );

    muldiv_absval #(.N(2 * WIDTH)) uFixProd (
        .neg (qNeg),
        .val ({rem, quo}),
        .res (prodFix)
    );

    muldiv_absval #(.N(WIDTH)) uFixQuo (
        .neg (qNeg),
        .val (quo),
        .res (quoFix)
    );

    muldiv_absval #(.N(WIDTH)) uFixRem (
        .neg (rNeg),
        .val (rem),
        .res (remFix)
    );

    assign mulSum   = {1'b0, rem} + (quo[0] ? opnd : '0);
    assign divShift = {rem, quo[WIDTH-1]};
    assign divDiff  = {1'b0, divShift} - {1'b0, opnd};

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = divByZero ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (lastIter) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                stateNext = flush ? IDLE : DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            cnt      <= '0;
            opDiv    <= 1'b0;
            qNeg     <= 1'b0;
            rNeg     <= 1'b0;
            opnd     <= '0;
            rem      <= '0;
            quo      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    if (start) begin
                        opDiv    <= isDiv;
                        div_zero <= divByZero;
                        cnt      <= '0;
                        qNeg     <= negA ^ negB;
                        rNeg     <= negA;
                        rem      <= '0;
                        // opnd: multiplicand or divisor; quo: multiplier or dividend
                        opnd     <= isDiv ? magB : magA;
                        quo      <= isDiv ? magA[WIDTH-1:0] : magB[WIDTH-1:0];
                    end
                end
                CALC: begin
                    if (!flush && !lastIter) begin
                        cnt <= cnt + CW'(1);
                        if (opDiv) begin
                            if (!divDiff[WIDTH+1]) begin
                                rem <= divDiff[WIDTH-1:0];
                                quo <= {quo[WIDTH-2:0], 1'b1};
                            end else begin
                                rem <= divShift[WIDTH-1:0];
                                quo <= {quo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            rem <= mulSum[WIDTH:1];
                            quo <= {mulSum[0], quo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (opDiv) begin
                            hi <= remFix;
                            lo <= quoFix;
                        end else begin
                            {hi, lo} <= prodFix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and width of each of the Hi and Lo registers; legal values are 8 to 64.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a, b  input  WIDTH each  operand A (multiplicand or dividend) and operand B (multiplier or divisor).
REQ-007 flush  input  1  synchronous abort of the operation in progress.
REQ-008 wr_hi, wr_lo, wr_data  input  1, 1, WIDTH  direct write into Hi and Lo (MTHI/MTLO).
REQ-009 hi, lo  output  WIDTH each  architectural Hi and Lo registers.
REQ-010 busy, done, div_zero  output  1 each  operation in progress; one-cycle completion pulse; divide-by-zero flag.

Function
REQ-011 The FSM states shall be IDLE, CALC, FIX and DONE.
REQ-012 In IDLE, start=1 at an edge shall capture |a|, |b|, the result signs and op; it shall then enter CALC with busy=1.
REQ-013 For signed ops, magnitudes shall be two's-complement absolute values held in WIDTH+1 bits, so the most-negative operand is handled correctly.
REQ-014 CALC shall run exactly WIDTH iterations, counted by an internal counter, then enter FIX.
REQ-015 MULT/MULTU in CALC: radix-2 shift-add, producing a 2*WIDTH-bit product.
REQ-016 DIV/DIVU in CALC: restoring division, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
REQ-017 FIX shall negate the result where required: product sign = sign(a) XOR sign(b); quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-018 On the edge leaving FIX, the unit shall write {hi,lo} = product for multiplies, or hi = remainder and lo = quotient for divides, then enter DONE.
REQ-019 DONE shall last one cycle with done=1 and busy=0, then return to IDLE.
REQ-020 Latency: done shall be high in the cycle that starts WIDTH+2 edges after the start edge.
REQ-021 DIV/DIVU with b=0 at start shall go directly to DONE with div_zero=1, leaving hi and lo unchanged.
REQ-022 div_zero shall hold its value until the next accepted start.
REQ-023 start while busy shall be ignored, with no queueing.
REQ-024 flush=1 in CALC or FIX shall return the FSM to IDLE at the next edge, with no done pulse and hi and lo unchanged.
REQ-025 flush shall have priority over all other inputs; flush in IDLE or DONE shall have no effect.
REQ-026 wr_hi and wr_lo shall take effect only in IDLE and shall be ignored while busy=1.
REQ-027 If start and wr_hi/wr_lo are both asserted in IDLE, the write shall happen and the operation shall start; the operation's result later overwrites Hi/Lo.
REQ-028 done and busy shall be mutually exclusive.

Reset
REQ-029 reset=0 shall, asynchronously, set the FSM to IDLE and set hi=0, lo=0, busy=0, done=0, div_zero=0, and clear the counter and working registers.
REQ-030 Reset asserted mid-operation shall discard the partial result.

Configuration
REQ-031 Macro MULDIV_UNSIGNED_EN compiles in the unsigned ops.
REQ-032 With MULDIV_UNSIGNED_EN defined: op[0]=1 selects MULTU/DIVU as specified.
REQ-033 Without MULDIV_UNSIGNED_EN: op[0] is ignored, every operation is signed, and the unsigned datapath logic is removed.

Structure
REQ-034 Shared package muldiv_pkg shall hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state encoding.
REQ-035 One sub-module, muldiv_absval, shall provide the combinational conditional two's-complement negate; it is used for operand magnitudes and result fix-up.

Verification (WIDTH=32)
REQ-036 MULT a=FFFFFFFD (-3), b=5 -> done at start+34, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-037 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; the same stimulus built without MULDIV_UNSIGNED_EN -> hi=00000000, lo=00000001.
REQ-038 DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-039 DIV a=80000000, b=0 with hi=lo=12345678 beforehand -> done one cycle after start, div_zero=1, hi=lo=12345678.
REQ-040 MULT 6*7 with flush at start+10 -> busy=0 at start+11, no done pulse, hi/lo unchanged; a start at start+5 during that operation is ignored.
REQ-041 reset=0 pulsed mid-CALC -> all outputs 0 immediately without a clock edge; wr_lo with wr_data=AA in IDLE -> lo=AA at the next edge.
